// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: redirect/hazard controls from ID, the instruction-memory
// port, and the IF/ID pipeline register outputs.
interface fetch_pc_unit_if;
  logic        Stall;
  logic        Flush;
  logic [1:0]  PCSrc;
  logic [31:0] BranchBase;
  logic [31:0] BranchOffset;
  logic [25:0] JumpIndex;
  logic [31:0] JRTarget;
  logic [31:0] InstrIn;
  logic [31:0] PC_out;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        AddrErr;

  // ID/hazard side and instruction memory drive the fetch unit
  modport master (
    output Stall, Flush, PCSrc, BranchBase, BranchOffset, JumpIndex, JRTarget,
           InstrIn,
    input  PC_out, IFID_Instr, IFID_PCPlus4, IFID_Valid, AddrErr
  );

  modport slave (
    input  Stall, Flush, PCSrc, BranchBase, BranchOffset, JumpIndex, JRTarget,
           InstrIn,
    output PC_out, IFID_Instr, IFID_PCPlus4, IFID_Valid, AddrErr
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS instruction-fetch stage: program counter with four-way next-PC select,
// IF/ID pipeline register with stall/flush, and a jr misalignment flag.
// Every output comes straight from a register.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic            Clk,
  input logic            Rst,
  fetch_pc_unit_if.slave bus
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  // Shifting the whole offset drops bits 31:30, same as {off[29:0],2'b00}
  assign branch_tgt = bus.BranchBase + (bus.BranchOffset << 2);
  assign jump_tgt   = {bus.BranchBase[31:28], bus.JumpIndex, 2'b00};
  assign jr_tgt     = {bus.JRTarget[31:2], 2'b00};

  // Next-PC source select
  always_comb begin
    next_pc = pc_plus4;
    case (bus.PCSrc)
      SRC_SEQ:    next_pc = pc_plus4;
      SRC_BRANCH: next_pc = branch_tgt;
      SRC_JUMP:   next_pc = jump_tgt;
      SRC_JR:     next_pc = jr_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

  // Next-state for PC, IF/ID and AddrErr; flush beats stall for IF/ID
  always_comb begin
    pc_d           = pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    ifid_valid_d   = ifid_valid_q;
    addr_err_d     = 1'b0;
    if (!bus.Stall) begin
      pc_d       = next_pc;
      addr_err_d = (bus.PCSrc == SRC_JR) && (bus.JRTarget[1:0] != 2'b00);
    end
    if (bus.Flush) begin
      ifid_instr_d   = NOP_WORD;
      ifid_pcplus4_d = 32'd0;
      ifid_valid_d   = 1'b0;
    end else if (!bus.Stall) begin
      ifid_instr_d   = bus.InstrIn;
      ifid_pcplus4_d = pc_plus4;
      ifid_valid_d   = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q           <= RESET_PC;
      ifid_instr_q   <= NOP_WORD;
      ifid_pcplus4_q <= 32'd0;
      ifid_valid_q   <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      ifid_valid_q   <= ifid_valid_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign bus.PC_out       = pc_q;
  assign bus.IFID_Instr   = ifid_instr_q;
  assign bus.IFID_PCPlus4 = ifid_pcplus4_q;
  assign bus.IFID_Valid   = ifid_valid_q;
  assign bus.AddrErr      = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a vector table walked edge by edge,
// plus hand sequences for reset during a redirect.
module tb_fetch_pc_unit;

  logic Clk = 1'b0;
  logic Rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Instruction memory model: word fetched is the bitwise inverse of its address
  assign bus.InstrIn = ~bus.PC_out;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  pcsrc;
    logic [31:0] bbase;
    logic [31:0] boff;
    logic [25:0] jidx;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_aerr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid, input logic aerr);
    chk32({tag, " PC_out"},       bus.PC_out,         pc);
    chk32({tag, " IFID_Instr"},   bus.IFID_Instr,     instr);
    chk32({tag, " IFID_PCPlus4"}, bus.IFID_PCPlus4,   pc4);
    chk32({tag, " IFID_Valid"},   {31'd0, bus.IFID_Valid}, {31'd0, valid});
    chk32({tag, " AddrErr"},      {31'd0, bus.AddrErr},    {31'd0, aerr});
  endtask

  task automatic drive(input logic stall, input logic flush, input logic [1:0] pcsrc,
                       input logic [31:0] bbase, input logic [31:0] boff,
                       input logic [25:0] jidx, input logic [31:0] jrt);
    bus.Stall        = stall;
    bus.Flush        = flush;
    bus.PCSrc        = pcsrc;
    bus.BranchBase   = bbase;
    bus.BranchOffset = boff;
    bus.JumpIndex    = jidx;
    bus.JRTarget     = jrt;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //               stall flush src  bbase         boff          jidx         jrt           pc            instr         pc4           v     ae
    // sequential fetch after reset
    vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0008, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h0000_000C, 32'hFFFF_FFF7, 32'h0000_000C, 1'b1, 1'b0};
    // jump with flush
    vecs[3]  = '{1'b0, 1'b1, 2'b10, 32'h4000_0010, 32'h0,        26'h000_0100, 32'h0,       32'h4000_0400, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h4000_0404, 32'hBFFF_FBFF, 32'h4000_0404, 1'b1, 1'b0};
    // branch backward (flushed) then forward (not flushed)
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'hFFFF_FFFE, 26'h0,      32'h0,        32'h0000_0018, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0020, 32'h0000_0003, 26'h0,      32'h0,        32'h0000_002C, 32'hFFFF_FFE7, 32'h0000_001C, 1'b1, 1'b0};
    // jr misaligned then aligned
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'h0,         32'h0,        26'h0,       32'h0000_1003, 32'h0000_1000, 32'hFFFF_FFD3, 32'h0000_0030, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b11, 32'h0,         32'h0,        26'h0,       32'h0000_2000, 32'h0000_2000, 32'hFFFF_EFFF, 32'h0000_1004, 1'b1, 1'b0};
    // stall three cycles with a jump presented: nothing moves
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h4000_0010, 32'h0,        26'h000_0100, 32'h0,       32'h0000_2000, 32'hFFFF_EFFF, 32'h0000_1004, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h4000_0010, 32'h0,        26'h000_0100, 32'h0,       32'h0000_2000, 32'hFFFF_EFFF, 32'h0000_1004, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h4000_0010, 32'h0,        26'h000_0100, 32'h0,       32'h0000_2000, 32'hFFFF_EFFF, 32'h0000_1004, 1'b1, 1'b0};
    // stall + flush: PC holds, IF/ID bubble
    vecs[12] = '{1'b1, 1'b1, 2'b10, 32'h4000_0010, 32'h0,        26'h000_0100, 32'h0,       32'h0000_2000, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h0000_2004, 32'hFFFF_DFFF, 32'h0000_2004, 1'b1, 1'b0};
    // load top-of-memory via jr, then wrap
    vecs[14] = '{1'b0, 1'b0, 2'b11, 32'h0,         32'h0,        26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_DFFB, 32'h0000_2008, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0,         32'h0,        26'h0,       32'h0,        32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0};
    // stalled misaligned jr: no AddrErr, no redirect
    vecs[16] = '{1'b1, 1'b0, 2'b11, 32'h0,         32'h0,        26'h0,       32'h0000_1003, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0};

    // Reset, with a conflicting redirect presented to show Rst wins
    Rst = 1'b1;
    drive(1'b0, 1'b0, 2'b10, 32'h4000_0010, 32'h0, 26'h000_0100, 32'h0);
    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    Rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].pcsrc, vecs[i].bbase,
            vecs[i].boff, vecs[i].jidx, vecs[i].jrt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                vecs[i].exp_pc4, vecs[i].exp_valid, vecs[i].exp_aerr);
    end

    // AddrErr pulse is one cycle wide even when the misaligned jr repeats under stall
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 32'h0000_1003);
    step();
    chk32("aerr pulse set", {31'd0, bus.AddrErr}, 32'd1);
    drive(1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 32'h0000_1003);
    step();
    chk32("aerr pulse clear", {31'd0, bus.AddrErr}, 32'd0);
    chk32("aerr pc", bus.PC_out, 32'h0000_1000);

    // Misaligned jr, then reset during a flushed jump redirect
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 32'h0000_3001);
    step();
    chk32("pre-reset aerr", {31'd0, bus.AddrErr}, 32'd1);
    chk32("pre-reset pc", bus.PC_out, 32'h0000_3000);
    Rst = 1'b1;
    drive(1'b0, 1'b1, 2'b10, 32'h4000_0010, 32'h0, 26'h000_0100, 32'h0);
    step();
    check_all("midrun reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // First non-reset edge captures the word at RESET_PC
    Rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 26'h0, 32'h0);
    step();
    check_all("post reset", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
